// File: rtl/chess_timer_pkg.sv
// Shared definitions for the chess clock: FSM state encoding and default widths.
package chess_timer_pkg;

   localparam int DEF_TIME_W     = 16;
   localparam int DEF_INC_W      = 8;
   localparam int DEF_RESET_TIME = 300;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN1    = 3'd1,
      ST_RUN2    = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_FLAGGED = 3'd4
   } state_e;

endpackage

// File: rtl/chess_timer_if.sv
// Player-facing controls and clock display outputs of the chess clock.
interface chess_timer_if
   import chess_timer_pkg::*;
#(
   parameter int TIME_W = DEF_TIME_W,
   parameter int INC_W  = DEF_INC_W
);
   logic              TICK;
   logic              LOAD;
   logic [TIME_W-1:0] INIT_TIME;
   logic [INC_W-1:0]  INC;
   logic              PRESS1;
   logic              PRESS2;
   logic              PAUSE;
   logic [TIME_W-1:0] TIM1;
   logic [TIME_W-1:0] TIM2;
   logic [1:0]        ACTIVE;
   logic              FLAG1;
   logic              FLAG2;
   logic [2:0]        STATE;

   modport master (
      output TICK, LOAD, INIT_TIME, INC, PRESS1, PRESS2, PAUSE,
      input  TIM1, TIM2, ACTIVE, FLAG1, FLAG2, STATE
   );

   modport slave (
      input  TICK, LOAD, INIT_TIME, INC, PRESS1, PRESS2, PAUSE,
      output TIM1, TIM2, ACTIVE, FLAG1, FLAG2, STATE
   );

endinterface

// File: rtl/chess_timer_counter.sv
// One player's remaining-time counter with sticky timeout flag.
// CHESS_TIMER_INC_EN builds the saturating Fischer increment; otherwise moves add nothing.
module chess_timer_counter #(
   parameter int                TIME_W     = 16,
   parameter int                INC_W      = 8,
   parameter logic [TIME_W-1:0] RESET_TIME = TIME_W'(300)
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              load_i,
   input  logic [TIME_W-1:0] init_i,
   input  logic              dec_i,
   input  logic              add_i,
   input  logic [INC_W-1:0]  inc_i,
   output logic [TIME_W-1:0] tim_o,
   output logic              flag_o,
   output logic              expire_o
);

   logic [TIME_W-1:0] tim_q, tim_d;
   logic              flag_q, flag_d;
   logic [TIME_W-1:0] moved;

   // A tick at 1 (or already at 0) runs the clock out; the move is then void.
   assign expire_o = dec_i && (tim_q <= TIME_W'(1));

`ifdef CHESS_TIMER_INC_EN
   logic [TIME_W:0] sum;

   always_comb begin
      sum   = {1'b0, tim_q} + (add_i ? (TIME_W+1)'(inc_i) : '0) - (TIME_W+1)'(dec_i);
      moved = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
   end
`else
   logic unused_inc;

   assign unused_inc = ^{inc_i, add_i};

   always_comb begin
      moved = tim_q - TIME_W'(dec_i);
   end
`endif

   always_comb begin
      tim_d  = tim_q;
      flag_d = flag_q;
      if (load_i) begin
         tim_d  = init_i;
         flag_d = 1'b0;
      end else if (expire_o) begin
         tim_d  = '0;
         flag_d = 1'b1;
      end else begin
         tim_d  = moved;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         tim_q  <= RESET_TIME;
         flag_q <= 1'b0;
      end else begin
         tim_q  <= tim_d;
         flag_q <= flag_d;
      end
   end

   assign tim_o  = tim_q;
   assign flag_o = flag_q;

endmodule

// File: rtl/chess_timer.sv
// Two-player chess clock: turn FSM, pause-side memory and output registers.
// Fischer increment is built only when CHESS_TIMER_INC_EN is defined.
//
//   state      | meaning
//   IDLE       | clocks loaded, waiting for first press
//   RUN1       | player 1's clock counting down
//   RUN2       | player 2's clock counting down
//   PAUSED     | both clocks stopped, side_q remembers who resumes
//   FLAGGED    | a clock ran out; everything frozen until LOAD/CLR
module chess_timer
   import chess_timer_pkg::*;
#(
   parameter int                TIME_W     = DEF_TIME_W,
   parameter int                INC_W      = DEF_INC_W,
   parameter logic [TIME_W-1:0] RESET_TIME = TIME_W'(DEF_RESET_TIME)
) (
   input  logic         CLK,
   input  logic         CLR,
   chess_timer_if.slave bus
);

   state_e      state_q, state_d;
   logic        side_q, side_d;
   logic [1:0]  active_q, active_d;
   logic        dec1, dec2, add1, add2;
   logic        exp1, exp2;

   // PAUSE wins over a same-cycle press of the running side.
   assign dec1 = (state_q == ST_RUN1) && bus.TICK;
   assign dec2 = (state_q == ST_RUN2) && bus.TICK;
   assign add1 = (state_q == ST_RUN1) && bus.PRESS1 && !bus.PAUSE;
   assign add2 = (state_q == ST_RUN2) && bus.PRESS2 && !bus.PAUSE;

   chess_timer_counter #(
      .TIME_W    (TIME_W),
      .INC_W     (INC_W),
      .RESET_TIME(RESET_TIME)
   ) u_cnt1 (
      .CLK     (CLK),
      .CLR     (CLR),
      .load_i  (bus.LOAD),
      .init_i  (bus.INIT_TIME),
      .dec_i   (dec1),
      .add_i   (add1),
      .inc_i   (bus.INC),
      .tim_o   (bus.TIM1),
      .flag_o  (bus.FLAG1),
      .expire_o(exp1)
   );

   chess_timer_counter #(
      .TIME_W    (TIME_W),
      .INC_W     (INC_W),
      .RESET_TIME(RESET_TIME)
   ) u_cnt2 (
      .CLK     (CLK),
      .CLR     (CLR),
      .load_i  (bus.LOAD),
      .init_i  (bus.INIT_TIME),
      .dec_i   (dec2),
      .add_i   (add2),
      .inc_i   (bus.INC),
      .tim_o   (bus.TIM2),
      .flag_o  (bus.FLAG2),
      .expire_o(exp2)
   );

   always_comb begin
      state_d = state_q;
      side_d  = side_q;
      if (bus.LOAD) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.PRESS2)      state_d = ST_RUN1;
               else if (bus.PRESS1) state_d = ST_RUN2;
            end
            ST_RUN1: begin
               if (exp1) begin
                  state_d = ST_FLAGGED;
               end else if (bus.PAUSE) begin
                  state_d = ST_PAUSED;
                  side_d  = 1'b0;
               end else if (bus.PRESS1) begin
                  state_d = ST_RUN2;
               end
            end
            ST_RUN2: begin
               if (exp2) begin
                  state_d = ST_FLAGGED;
               end else if (bus.PAUSE) begin
                  state_d = ST_PAUSED;
                  side_d  = 1'b1;
               end else if (bus.PRESS2) begin
                  state_d = ST_RUN1;
               end
            end
            ST_PAUSED: begin
               if (bus.PAUSE) state_d = side_q ? ST_RUN2 : ST_RUN1;
            end
            ST_FLAGGED: state_d = ST_FLAGGED;
            default:    state_d = ST_IDLE;
         endcase
      end

      active_d = 2'b00;
      if (state_d == ST_RUN1)      active_d = 2'b01;
      else if (state_d == ST_RUN2) active_d = 2'b10;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q  <= ST_IDLE;
         side_q   <= 1'b0;
         active_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         side_q   <= side_d;
         active_q <= active_d;
      end
   end

   assign bus.ACTIVE = active_q;
   assign bus.STATE  = state_q;

endmodule

// File: tb/tb_chess_timer.sv
// Directed scoreboard bench for chess_timer; expectations follow CHESS_TIMER_INC_EN.
module tb_chess_timer;

`ifdef CHESS_TIMER_INC_EN
   localparam bit INC_ON = 1'b1;
`else
   localparam bit INC_ON = 1'b0;
`endif

   localparam logic [2:0] S_IDLE = 3'd0, S_RUN1 = 3'd1, S_RUN2 = 3'd2,
                          S_PAUSED = 3'd3, S_FLAGGED = 3'd4;

   typedef struct {
      string       name;
      logic [15:0] t1;
      logic [15:0] t2;
      logic [1:0]  act;
      logic        f1;
      logic        f2;
      logic [2:0]  st;
   } exp_t;

   logic CLK;
   logic CLR;
   int   total;
   int   bad;
   bit   done;
   exp_t exp_q[$];

   chess_timer_if #(.TIME_W(16), .INC_W(8)) bus ();

   chess_timer #(
      .TIME_W    (16),
      .INC_W     (8),
      .RESET_TIME(16'd300)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .bus(bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic expect_out(input string name, input logic [15:0] t1, input logic [15:0] t2,
                             input logic [1:0] act, input logic f1, input logic f2,
                             input logic [2:0] st);
      exp_t e;
      e.name = name; e.t1 = t1; e.t2 = t2; e.act = act; e.f1 = f1; e.f2 = f2; e.st = st;
      exp_q.push_back(e);
   endtask

   task automatic check_now(input string name, input logic [15:0] t1, input logic [15:0] t2,
                            input logic [1:0] act, input logic f1, input logic f2,
                            input logic [2:0] st);
      total++;
      if ({bus.TIM1, bus.TIM2, bus.ACTIVE, bus.FLAG1, bus.FLAG2, bus.STATE} !==
          {t1, t2, act, f1, f2, st}) begin
         bad++;
         $display("FAIL %s (immediate): got tim1=%0d tim2=%0d act=%b f1=%b f2=%b st=%0d, want tim1=%0d tim2=%0d act=%b f1=%b f2=%b st=%0d",
                  name, bus.TIM1, bus.TIM2, bus.ACTIVE, bus.FLAG1, bus.FLAG2, bus.STATE,
                  t1, t2, act, f1, f2, st);
      end
   endtask

   task automatic cyc(input bit tk, input bit p1, input bit p2, input bit ps, input bit ld);
      bus.TICK = tk; bus.PRESS1 = p1; bus.PRESS2 = p2; bus.PAUSE = ps; bus.LOAD = ld;
      @(posedge CLK);
      #1;
      bus.TICK = 1'b0; bus.PRESS1 = 1'b0; bus.PRESS2 = 1'b0; bus.PAUSE = 1'b0; bus.LOAD = 1'b0;
   endtask

   always @(negedge CLK) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if ({bus.TIM1, bus.TIM2, bus.ACTIVE, bus.FLAG1, bus.FLAG2, bus.STATE} !==
             {e.t1, e.t2, e.act, e.f1, e.f2, e.st}) begin
            bad++;
            $display("FAIL %s: got tim1=%0d tim2=%0d act=%b f1=%b f2=%b st=%0d, want tim1=%0d tim2=%0d act=%b f1=%b f2=%b st=%0d",
                     e.name, bus.TIM1, bus.TIM2, bus.ACTIVE, bus.FLAG1, bus.FLAG2, bus.STATE,
                     e.t1, e.t2, e.act, e.f1, e.f2, e.st);
         end
      end
   end

   initial begin
      done = 1'b0;
      #200000;
      if (!done) begin
         $display("FAIL timeout: test sequence did not finish");
         $display("test done: total=%0d bad=%0d", total, bad + 1);
         $finish;
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      CLR   = 1'b1;
      bus.TICK = 1'b0; bus.LOAD = 1'b0; bus.PRESS1 = 1'b0; bus.PRESS2 = 1'b0; bus.PAUSE = 1'b0;
      bus.INIT_TIME = 16'd0;
      bus.INC       = 8'd0;

      @(posedge CLK); #1;
      check_now("reset_held", 300, 300, 2'b00, 0, 0, S_IDLE);
      @(posedge CLK); #1;
      CLR = 1'b0;
      cyc(0, 0, 0, 0, 0);
      expect_out("reset_release", 300, 300, 2'b00, 0, 0, S_IDLE);

      cyc(0, 0, 1, 0, 0);
      expect_out("idle_press2", 300, 300, 2'b01, 0, 0, S_RUN1);
      repeat (3) cyc(1, 0, 0, 0, 0);
      expect_out("three_ticks", 297, 300, 2'b01, 0, 0, S_RUN1);
      cyc(0, 1, 0, 0, 0);
      expect_out("press1_inc0", 297, 300, 2'b10, 0, 0, S_RUN2);
      cyc(1, 0, 0, 0, 0);
      expect_out("tick_run2", 297, 299, 2'b10, 0, 0, S_RUN2);
      cyc(0, 0, 0, 1, 0);
      expect_out("pause_run2", 297, 299, 2'b00, 0, 0, S_PAUSED);
      repeat (5) cyc(1, 0, 0, 0, 0);
      expect_out("ticks_paused", 297, 299, 2'b00, 0, 0, S_PAUSED);
      cyc(0, 0, 0, 1, 0);
      expect_out("resume_run2", 297, 299, 2'b10, 0, 0, S_RUN2);
      cyc(1, 0, 0, 0, 0);
      expect_out("tick_after_resume", 297, 298, 2'b10, 0, 0, S_RUN2);
      cyc(1, 1, 0, 0, 0);
      expect_out("other_press_ignored", 297, 297, 2'b10, 0, 0, S_RUN2);
      cyc(0, 0, 1, 1, 0);
      expect_out("pause_beats_press", 297, 297, 2'b00, 0, 0, S_PAUSED);
      cyc(0, 0, 0, 1, 0);
      expect_out("resume_stored_side", 297, 297, 2'b10, 0, 0, S_RUN2);

      bus.INIT_TIME = 16'd10; bus.INC = 8'd2;
      cyc(1, 1, 1, 1, 1);
      expect_out("load_priority", 10, 10, 2'b00, 0, 0, S_IDLE);
      cyc(0, 0, 0, 1, 0);
      expect_out("pause_idle_ignored", 10, 10, 2'b00, 0, 0, S_IDLE);
      cyc(0, 0, 1, 0, 0);
      repeat (4) cyc(1, 0, 0, 0, 0);
      expect_out("four_ticks", 6, 10, 2'b01, 0, 0, S_RUN1);
      cyc(0, 1, 0, 0, 0);
      expect_out("fischer_inc2", INC_ON ? 16'd8 : 16'd6, 10, 2'b10, 0, 0, S_RUN2);

      bus.INIT_TIME = 16'd100; bus.INC = 8'd3;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 1, 0, 0);
      expect_out("both_pressed_run1", 100, 100, 2'b01, 0, 0, S_RUN1);
      cyc(1, 1, 0, 0, 0);
      expect_out("tick_and_press", INC_ON ? 16'd102 : 16'd99, 100, 2'b10, 0, 0, S_RUN2);

      bus.INIT_TIME = 16'd1;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      expect_out("run1_at_one", 1, 1, 2'b01, 0, 0, S_RUN1);
      cyc(1, 1, 0, 0, 0);
      expect_out("flag1_same_press", 0, 1, 2'b00, 1, 0, S_FLAGGED);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 1, 0, 0);
      expect_out("flagged_frozen", 0, 1, 2'b00, 1, 0, S_FLAGGED);

      bus.INIT_TIME = 16'd0;
      cyc(0, 0, 0, 0, 1);
      expect_out("load_clears_flags", 0, 0, 2'b00, 0, 0, S_IDLE);
      cyc(0, 1, 0, 0, 0);
      expect_out("start_at_zero", 0, 0, 2'b10, 0, 0, S_RUN2);
      cyc(1, 0, 0, 0, 0);
      expect_out("flag2_from_zero", 0, 0, 2'b00, 0, 1, S_FLAGGED);

      bus.INIT_TIME = 16'd65534; bus.INC = 8'd5;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect_out("saturate_press", INC_ON ? 16'd65535 : 16'd65534, 65534, 2'b10, 0, 0, S_RUN2);
      cyc(1, 0, 1, 0, 0);
      expect_out("saturate_tick_press", INC_ON ? 16'd65535 : 16'd65534,
                 INC_ON ? 16'd65535 : 16'd65533, 2'b01, 0, 0, S_RUN1);
      cyc(0, 1, 0, 1, 0);
      expect_out("pause_run1_press", INC_ON ? 16'd65535 : 16'd65534,
                 INC_ON ? 16'd65535 : 16'd65533, 2'b00, 0, 0, S_PAUSED);
      cyc(0, 0, 0, 1, 0);
      expect_out("resume_run1", INC_ON ? 16'd65535 : 16'd65534,
                 INC_ON ? 16'd65535 : 16'd65533, 2'b01, 0, 0, S_RUN1);

      cyc(1, 0, 0, 0, 0);
      #2;
      CLR = 1'b1;
      #1;
      check_now("async_clr", 300, 300, 2'b00, 0, 0, S_IDLE);
      @(posedge CLK); #1;
      CLR = 1'b0;
      cyc(0, 1, 0, 0, 0);
      expect_out("after_clr_no_inc", 300, 300, 2'b10, 0, 0, S_RUN2);

      @(negedge CLK);
      #1;
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chess_timer.md
CHESS_TIMER -- requirements
Module: chess_timer

Interface
REQ-001 Parameter TIME_W, default 16, width of each player's remaining-time counter in ticks.
REQ-002 Parameter INC_W, default 8, width of the per-move increment.
REQ-003 Parameter RESET_TIME, default 16'd300, value loaded into both counters by CLR.
REQ-004 Port CLK  input  1  clock; all state changes on rising edge.
REQ-005 Port CLR  input  1  reset, asynchronous, active-high.
REQ-006 Port TICK  input  1  one-cycle time-base strobe; one strobe = one time unit.
REQ-007 Port LOAD  input  1  synchronous reload of both counters from INIT_TIME.
REQ-008 Port INIT_TIME  input  TIME_W  start time for LOAD.
REQ-009 Port INC  input  INC_W  Fischer increment added on a move.
REQ-010 Port PRESS1 / PRESS2  input  1 each  one-cycle button pulses; player N ends own turn.
REQ-011 Port PAUSE  input  1  one-cycle pulse; toggles pause.
REQ-012 Port TIM1 / TIM2  output  TIME_W each  remaining time, registered.
REQ-013 Port ACTIVE  output  2  one-hot running side (bit0 = player 1); 2'b00 when no clock runs.
REQ-014 Port FLAG1 / FLAG2  output  1 each  sticky timeout flag per player.
REQ-015 Port STATE  output  3  current FSM state encoding.

Function
REQ-016 FSM states: IDLE, RUN1, RUN2, PAUSED, FLAGGED.
REQ-017 IDLE: PRESS1 -> RUN2; PRESS2 -> RUN1; both pressed in the same cycle -> RUN1; no increment applied on start.
REQ-018 RUN1: TICK decrements TIM1 by 1; PRESS1 -> TIM1 += INC, go to RUN2; PRESS2 ignored; RUN2 mirrors this.
REQ-019 TICK and PRESS of the running side in the same cycle: TIM = TIM - 1 + INC in one step.
REQ-020 Decrement reaching 0 -> TIM held at 0, raise that player's FLAG, go to FLAGGED; a same-cycle press is ignored and no increment is added.
REQ-021 Increment addition saturates at 2^TIME_W-1; no wrap-around.
REQ-022 PAUSE in RUN1/RUN2 -> PAUSED, running side stored; PAUSE in PAUSED -> resume the stored side; PAUSE in IDLE/FLAGGED is ignored.
REQ-023 PAUSE has priority over a same-cycle PRESS; TICK is ignored in IDLE, PAUSED and FLAGGED.
REQ-024 FLAGGED is terminal: counters and flags frozen until LOAD or CLR.
REQ-025 LOAD in any state: TIM1 = TIM2 = INIT_TIME, FLAGs cleared, go to IDLE; LOAD has priority over all other inputs.
REQ-026 Start from IDLE with a counter already at 0: the next TICK in the RUN state flags that player.
REQ-027 All outputs registered; effect visible the cycle after the triggering edge.
REQ-028 ACTIVE = 2'b01 in RUN1, 2'b10 in RUN2, 2'b00 otherwise.

Reset
REQ-029 CLR asynchronously forces TIM1 = TIM2 = RESET_TIME, FLAG1 = FLAG2 = 0, ACTIVE = 0, state IDLE, stored pause side = player 1.
REQ-030 CLR mid-game abandons the game immediately; no pending press or increment survives.
REQ-031 CLR release is synchronous to CLK.

Configuration
REQ-032 Macro CHESS_TIMER_INC_EN defined: Fischer increment active per REQ-018/019/021.
REQ-033 Macro undefined: INC port present but ignored, moves add 0, and the saturation logic is not built.

Structure
REQ-034 Package chess_timer_pkg holds the FSM state enum/encoding and the default widths.
REQ-035 Sub-module chess_timer_counter, instantiated twice: per-player load, decrement, saturating add, zero detect.
REQ-036 The top level holds only the FSM, pause-side register and output muxing.

Verification
REQ-037 CLR, then PRESS2, then 3 TICKs -> TIM1 = 297, TIM2 = 300, ACTIVE = 01.
REQ-038 LOAD INIT_TIME = 10, INC = 2, PRESS2, 4 TICKs, PRESS1 -> TIM1 = 8, state RUN2 (with CHESS_TIMER_INC_EN).
REQ-039 TIM1 = 1 in RUN1, TICK and PRESS1 in the same cycle -> TIM1 = 0, FLAG1 = 1, FLAGGED; further PRESS/TICK leaves outputs unchanged.
REQ-040 RUN2, PAUSE, 5 TICKs, PAUSE -> TIM2 unchanged while paused, resumes in RUN2, ACTIVE = 10.
REQ-041 TIM1 = 65534, INC = 5, PRESS1 in RUN1 -> TIM1 = 65535 (saturated).
REQ-042 CLR asserted mid-RUN1, asynchronous to CLK -> outputs at reset values before the next clock edge.
